// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared line codes, receiver states and framing constants
package usb_rx_pkg;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        K   = 2'b01,
        J   = 2'b10,
        SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        ERR
    } rx_state_t;

    localparam int STUFF_LIMIT = 6;
    localparam int BYTE_BITS   = 8;

endpackage

// File: rtl/usb_rx_dpll.sv
// rtl/usb_rx_dpll.sv - pin synchroniser and transition-locked bit strobe
module usb_rx_dpll
    import usb_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dp,
    input  logic        dm,
    output line_state_t line_state,
    output logic        strobe,
    output line_state_t sample_state
);

    localparam int            CW      = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(CLK_PER_BIT / 2);

    logic [1:0]    meta_q;
    line_state_t   sync_q;
    line_state_t   prev_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 2'b10;
            sync_q <= J;
            prev_q <= J;
            cnt    <= '0;
        end else begin
            meta_q <= {dp, dm};
            sync_q <= line_state_t'(meta_q);
            prev_q <= sync_q;
            if (sync_q != prev_q) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Sampling the one-cycle-delayed level centres the strobe inside the bit.
    assign line_state   = sync_q;
    assign strobe       = (cnt == CNT_MID);
    assign sample_state = prev_q;

endmodule

// File: rtl/usb_fs_rx_phy.sv
// rtl/usb_fs_rx_phy.sv - full-speed USB receive front end with UTMI-style byte output
module usb_fs_rx_phy
    import usb_rx_pkg::*;
#(
    parameter int CLK_PER_BIT    = 4,
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int IDLE_BITS      = 8
) (
    input  logic       UTMI_clk,
    input  logic       Rst,
    input  logic       DP,
    input  logic       DM,
    input  logic       Rx_en,
    output logic [7:0] RX_data,
    output logic       RX_valid,
    output logic       RX_active,
    output logic       RX_error,
    output logic [1:0] Line_state
);

    localparam int            ZW        = $clog2(SYNC_MIN_ZEROS + 1);
    localparam int            IW        = $clog2(IDLE_BITS + 1);
    localparam logic [ZW-1:0] ZERO_MIN  = ZW'(SYNC_MIN_ZEROS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);
    localparam logic [2:0]    ONES_MAX  = 3'(STUFF_LIMIT);
    localparam logic [2:0]    LAST_BIT  = 3'(BYTE_BITS - 1);

    line_state_t line_state;
    line_state_t sample;
    logic        strobe;

    usb_rx_dpll #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_dpll (
        .clk          (UTMI_clk),
        .rst_n        (Rst),
        .dp           (DP),
        .dm           (DM),
        .line_state   (line_state),
        .strobe       (strobe),
        .sample_state (sample)
    );

    rx_state_t     state, state_n;
    logic [ZW-1:0] zero_cnt, zero_n;
    logic [2:0]    ones_cnt, ones_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic [7:0]    data_q, data_n;
    logic          valid_q, valid_n;
    logic          active_q, active_n;
    logic          error_q, error_n;
    logic          partial_q, partial_n;
    logic          se0_seen_q, se0_seen_n;
    logic [IW-1:0] idle_cnt, idle_n;
    line_state_t   prev_lvl, prev_n;
    logic          is_jk;
    logic          bit_dec;
    logic          do_error;

    always_ff @(posedge UTMI_clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            zero_cnt   <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            error_q    <= 1'b0;
            partial_q  <= 1'b0;
            se0_seen_q <= 1'b0;
            idle_cnt   <= '0;
            prev_lvl   <= J;
        end else begin
            state      <= state_n;
            zero_cnt   <= zero_n;
            ones_cnt   <= ones_n;
            bit_cnt    <= bit_n;
            shift_q    <= shift_n;
            data_q     <= data_n;
            valid_q    <= valid_n;
            active_q   <= active_n;
            error_q    <= error_n;
            partial_q  <= partial_n;
            se0_seen_q <= se0_seen_n;
            idle_cnt   <= idle_n;
            prev_lvl   <= prev_n;
        end
    end

    always_comb begin
        state_n    = state;
        zero_n     = zero_cnt;
        ones_n     = ones_cnt;
        bit_n      = bit_cnt;
        shift_n    = shift_q;
        data_n     = data_q;
        valid_n    = 1'b0;
        active_n   = active_q;
        error_n    = 1'b0;
        partial_n  = partial_q;
        se0_seen_n = se0_seen_q;
        idle_n     = idle_cnt;
        prev_n     = prev_lvl;
        is_jk      = (sample == J) || (sample == K);
        bit_dec    = (sample == prev_lvl);
        do_error   = 1'b0;

        if (!Rx_en) begin
            state_n    = IDLE;
            zero_n     = '0;
            ones_n     = '0;
            bit_n      = '0;
            partial_n  = 1'b0;
            se0_seen_n = 1'b0;
            idle_n     = '0;
            active_n   = 1'b0;
        end else if (strobe) begin
            if (is_jk) begin
                prev_n = sample;
            end
            unique case (state)
                IDLE: begin
                    if (sample == K) begin
                        state_n = SYNC;
                        zero_n  = ZW'(1);
                    end
                end
                SYNC: begin
                    if (!is_jk) begin
                        state_n = IDLE;
                    end else if (!bit_dec) begin
                        if (zero_cnt != ZERO_MIN) begin
                            zero_n = zero_cnt + 1'b1;
                        end
                    end else if (zero_cnt >= ZERO_MIN) begin
                        state_n  = DATA;
                        active_n = 1'b1;
                        ones_n   = '0;
                        bit_n    = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    if (sample == SE0) begin
                        state_n   = EOP;
                        partial_n = (bit_cnt != 3'd0);
                    end else if (sample == SE1) begin
                        do_error = 1'b1;
                    end else if (ones_cnt == ONES_MAX) begin
                        // Bit following a run of six ones must be a stuffed zero.
                        if (bit_dec) begin
                            do_error = 1'b1;
                        end else begin
                            ones_n = '0;
                        end
                    end else begin
                        ones_n  = bit_dec ? ones_cnt + 3'd1 : 3'd0;
                        shift_n = {bit_dec, shift_q[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            data_n  = shift_n;
                            valid_n = 1'b1;
                        end
                    end
                end
                EOP: begin
                    if (sample == J) begin
                        state_n  = IDLE;
                        active_n = 1'b0;
                        error_n  = partial_q;
                    end else if (sample != SE0) begin
                        do_error = 1'b1;
                    end
                end
                ERR: begin
                    if (sample == SE0) begin
                        se0_seen_n = 1'b1;
                        idle_n     = '0;
                    end else if (sample == J) begin
                        if (se0_seen_q || (idle_cnt == IDLE_LAST)) begin
                            state_n    = IDLE;
                            se0_seen_n = 1'b0;
                            idle_n     = '0;
                        end else begin
                            idle_n = idle_cnt + 1'b1;
                        end
                    end else begin
                        se0_seen_n = 1'b0;
                        idle_n     = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (do_error) begin
                state_n    = ERR;
                error_n    = 1'b1;
                active_n   = 1'b0;
                se0_seen_n = 1'b0;
                idle_n     = '0;
            end
        end
    end

    assign RX_data    = data_q;
    assign RX_valid   = valid_q;
    assign RX_active  = active_q;
    assign RX_error   = error_q;
    assign Line_state = line_state;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// tb/tb_usb_fs_rx_phy.sv - scoreboard bench for usb_fs_rx_phy
module tb_usb_fs_rx_phy;

    localparam int         CPB  = 4;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dp, dm, rx_en;
    logic [7:0] rx_data;
    logic       rx_valid, rx_active, rx_error;
    logic [1:0] line_state;

    always #5 clk = ~clk;

    usb_fs_rx_phy #(
        .CLK_PER_BIT    (CPB),
        .SYNC_MIN_ZEROS (5),
        .IDLE_BITS      (8)
    ) dut (
        .UTMI_clk   (clk),
        .Rst        (rst_n),
        .DP         (dp),
        .DM         (dm),
        .Rx_en      (rx_en),
        .RX_data    (rx_data),
        .RX_valid   (rx_valid),
        .RX_active  (rx_active),
        .RX_error   (rx_error),
        .Line_state (line_state)
    );

    typedef enum int {EV_RISE, EV_BYTE, EV_FALL, EV_ERRFALL, EV_ERR_ALONE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [1:0] lv_q[$];
    logic [7:0] pkt[$];
    int         total = 0;
    int         bad = 0;
    logic       prev_active = 1'b0;
    logic [1:0] cur_lvl;
    int         ones_run;
    int         offs;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    task automatic check_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got=%s/%0h required=none", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_BYTE && e.data != d)) begin
                bad++;
                $display("FAIL event got=%s/%0h required=%s/%0h", k.name(), d, e.kind.name(), e.data);
            end
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Output monitor: turns DUT pulses and RX_active edges into scoreboard events.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_active = 1'b0;
        end else begin
            if (rx_active && !prev_active) check_ev(EV_RISE, 8'h00);
            if (rx_valid) check_ev(EV_BYTE, rx_data);
            if (rx_valid && rx_error) check("valid_error_overlap", 32'd1, 32'd0);
            if (rx_error) check_ev((prev_active && !rx_active) ? EV_ERRFALL : EV_ERR_ALONE, 8'h00);
            else if (prev_active && !rx_active) check_ev(EV_FALL, 8'h00);
            prev_active = rx_active;
        end
    end

    task automatic put_raw(input bit b);
        if (!b) cur_lvl = (cur_lvl == LJ) ? LK : LJ;
        lv_q.push_back(cur_lvl);
    endtask

    task automatic put_data(input bit b);
        put_raw(b);
        ones_run = b ? ones_run + 1 : 0;
        if (ones_run == 6) begin
            put_raw(1'b0);
            ones_run = 0;
        end
    endtask

    task automatic put_idle(input int n);
        repeat (n) lv_q.push_back(LJ);
        cur_lvl = LJ;
    endtask

    task automatic put_sync();
        cur_lvl  = LJ;
        ones_run = 0;
        repeat (7) put_raw(1'b0);
        put_raw(1'b1);
    endtask

    task automatic put_eop();
        lv_q.push_back(LSE0);
        lv_q.push_back(LSE0);
        lv_q.push_back(LJ);
        cur_lvl = LJ;
    endtask

    // Each run of equal levels lasts n bit times, stretched or shrunk by one
    // cycle while the edge position stays within +-1 cycle of nominal.
    task automatic drive(input bit jitter);
        logic [1:0] l;
        int         n;
        int         d;
        offs = 0;
        while (lv_q.size() > 0) begin
            l = lv_q.pop_front();
            n = 1;
            while (lv_q.size() > 0 && lv_q[0] == l) begin
                void'(lv_q.pop_front());
                n++;
            end
            d = 0;
            if (jitter) begin
                d = int'($urandom_range(0, 2)) - 1;
                if (offs + d > 1 || offs + d < -1) d = 0;
                offs += d;
            end
            {dp, dm} = l;
            repeat (CPB * n + d) @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(input string name);
        repeat (12) @(posedge clk);
        #2;
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Reference model: SYNC gives a rise, every complete byte a valid, a
    // trailing partial byte turns the EOP fall into an error fall.
    task automatic send_packet(input int extra, input bit jitter, input string name);
        logic [7:0] b;
        expect_ev(EV_RISE, 8'h00);
        put_idle(2);
        put_sync();
        foreach (pkt[i]) begin
            b = pkt[i];
            for (int k = 0; k < 8; k++) put_data(b[k]);
            expect_ev(EV_BYTE, b);
        end
        for (int k = 0; k < extra; k++) put_data(1'($urandom));
        if (extra > 0) expect_ev(EV_ERRFALL, 8'h00);
        else expect_ev(EV_FALL, 8'h00);
        put_eop();
        put_idle(6);
        drive(jitter);
        wait_drain(name);
    endtask

    task automatic stuff_err(input bit via_se0);
        expect_ev(EV_RISE, 8'h00);
        expect_ev(EV_ERRFALL, 8'h00);
        put_idle(4);
        put_sync();
        repeat (7) put_raw(1'b1);
        if (via_se0) put_eop();
        else put_idle(12);
        drive(1'b0);
        repeat (4) @(posedge clk);
        #2;
        check("stuff_err_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_data"}, rx_data, 0);
        check({name, "_rx_valid"}, rx_valid, 0);
        check({name, "_rx_active"}, rx_active, 0);
        check({name, "_rx_error"}, rx_error, 0);
        check({name, "_line_state"}, line_state, LJ);
    endtask

    initial begin
        rst_n    = 1'b0;
        {dp, dm} = LJ;
        rx_en    = 1'b1;
        cur_lvl  = LJ;
        ones_run = 0;
        offs     = 0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;

        pkt = '{8'hA5};
        send_packet(0, 1'b0, "a5");
        pkt = '{8'hFF, 8'h00};
        send_packet(0, 1'b0, "ff_00");

        stuff_err(1'b1);
        pkt = '{8'h5A};
        send_packet(0, 1'b0, "after_se0_recover");
        stuff_err(1'b0);
        pkt = '{8'hC3};
        send_packet(0, 1'b0, "after_idle_recover");

        put_idle(2);
        cur_lvl = LJ;
        put_raw(1'b0);
        put_raw(1'b0);
        put_raw(1'b0);
        put_raw(1'b1);
        put_idle(10);
        drive(1'b0);
        wait_drain("trunc_sync");

        pkt = '{8'h3C};
        send_packet(3, 1'b0, "partial");

        expect_ev(EV_RISE, 8'h00);
        expect_ev(EV_FALL, 8'h00);
        put_idle(2);
        put_sync();
        for (int k = 0; k < 4; k++) put_data(1'($urandom));
        drive(1'b0);
        rx_en = 1'b0;
        for (int k = 0; k < 12; k++) put_data(1'($urandom));
        put_eop();
        put_idle(4);
        drive(1'b0);
        rx_en = 1'b1;
        wait_drain("rx_en");

        expect_ev(EV_RISE, 8'h00);
        put_idle(2);
        put_sync();
        for (int k = 0; k < 4; k++) put_data(1'($urandom));
        drive(1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        {dp, dm} = LJ;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("reset_drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (8) @(posedge clk);
        #2;
        pkt = '{8'h96, 8'h7E};
        send_packet(0, 1'b1, "post_reset");

        for (int p = 0; p < 16; p++) begin
            pkt.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) pkt.push_back(8'($urandom));
            send_packet(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0, 1'b1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
